// File: rtl/writeback_scheduler_pkg.sv
// Shared widths and load-queue entry type for the writeback scheduler.
package writeback_scheduler_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic                  valid;
    logic                  dead;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } lq_entry_t;
endpackage

// File: rtl/wb_load_queue.sv
// Circular load-return FIFO with a parallel rd-match kill port.
module wb_load_queue
  import writeback_scheduler_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  push_dead,
  input  logic [REG_ADDR_W-1:0] push_rd,
  input  logic [DATA_W-1:0]     push_data,
  input  logic                  pop,
  input  logic                  kill,
  input  logic [REG_ADDR_W-1:0] kill_rd,
  output lq_entry_t             head,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  lq_entry_t     mem_q [DEPTH];
  lq_entry_t     mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          pop_eff;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign head  = mem_q[head_q];
  assign count = count_q;
  assign overflow = ovf_q;
  assign pop_eff = pop && !empty;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    ovf_d   = ovf_q | (push && full && !pop);
    count_d = count_q + CW'(push) - CW'(pop_eff);
    if (kill) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mem_q[i].valid && mem_q[i].rd == kill_rd) begin
          mem_d[i].dead = 1'b1;
        end
      end
    end
    if (pop_eff) begin
      mem_d[head_q].valid = 1'b0;
      head_d = (head_q == LAST) ? '0 : head_q + 1'b1;
    end
    // push after pop so a full-queue swap reuses the freed slot
    if (push) begin
      mem_d[tail_q] = '{valid: 1'b1, dead: push_dead,
                        rd: push_rd, data: push_data};
      tail_d = (tail_q == LAST) ? '0 : tail_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: rtl/writeback_scheduler.sv
// Arbitrates the register-file write port between execute and load returns.
module writeback_scheduler
  import writeback_scheduler_pkg::*;
#(
  parameter int PC_WIDTH = 11,
  parameter int LQ_DEPTH = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          exec_valid,
  output logic                          exec_ready,
  input  logic [REG_ADDR_W-1:0]         exec_rd,
  input  logic [DATA_W-1:0]             exec_data,
  input  logic                          exec_link,
  input  logic [PC_WIDTH-1:0]           link_pc,
  input  logic                          load_valid,
  input  logic [REG_ADDR_W-1:0]         load_rd,
  input  logic [DATA_W-1:0]             load_data,
  output logic                          wr_en,
  output logic [REG_ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]             wr_data,
  output logic [$clog2(LQ_DEPTH+1)-1:0] lq_count,
  output logic                          overflow_err
);
  localparam int CW = $clog2(LQ_DEPTH + 1);

  lq_entry_t         head;
  logic              lq_full, lq_empty;
  logic              exec_eff, load_eff;
  logic              g_exec, g_pop, g_byp;
  logic              lq_push, lq_push_dead;
  logic [DATA_W-1:0] exec_wdata;
  logic [CW-1:0]     count;

  logic                  wr_en_q, wr_en_d;
  logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]     wr_data_q, wr_data_d;

  assign exec_eff   = exec_valid && exec_rd != ZERO_REG;
  assign load_eff   = load_valid && load_rd != ZERO_REG;
  assign exec_wdata = exec_link ? DATA_W'(link_pc) : exec_data;

  // one-hot port grant: a full queue outranks execute
  assign g_pop  = lq_full || (!exec_eff && !lq_empty);
  assign g_exec = !lq_full && exec_eff;
  assign g_byp  = !lq_full && !exec_eff && lq_empty && load_eff;

  assign exec_ready   = !g_pop || !exec_eff;
  assign lq_push      = load_eff && !g_byp;
  assign lq_push_dead = g_exec && load_rd == exec_rd;

  wb_load_queue #(
    .DEPTH (LQ_DEPTH),
    .CW    (CW)
  ) u_lq (
    .clock     (clock),
    .reset     (reset),
    .push      (lq_push),
    .push_dead (lq_push_dead),
    .push_rd   (load_rd),
    .push_data (load_data),
    .pop       (g_pop),
    .kill      (g_exec),
    .kill_rd   (exec_rd),
    .head      (head),
    .count     (count),
    .full      (lq_full),
    .empty     (lq_empty),
    .overflow  (overflow_err)
  );

  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    unique case (1'b1)
      g_exec: begin
        wr_en_d   = 1'b1;
        wr_addr_d = exec_rd;
        wr_data_d = exec_wdata;
      end
      g_pop: begin
        wr_en_d = head.valid && !head.dead;
        if (wr_en_d) begin
          wr_addr_d = head.rd;
          wr_data_d = head.data;
        end
      end
      g_byp: begin
        wr_en_d   = 1'b1;
        wr_addr_d = load_rd;
        wr_data_d = load_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign lq_count = count;
endmodule
